// File: rtl/hazard_forward_ctrl.sv
// Hazard controller for the 5-stage core: EX operand forwarding, load-use stalls, dmem wait freeze, branch flush.
// Optional performance counters are built when HAZ_PERF_CNT_EN is defined; otherwise stall_cnt/flush_cnt read 0.
module hazard_forward_ctrl #(
    parameter int NUM_SRC = 2,
    parameter int AW      = 5,
    parameter int LU_CYC  = 1,
    parameter int CNT_W   = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_SRC*AW-1:0]  rs_ex,
    input  logic [NUM_SRC*AW-1:0]  rs_id,
    input  logic [NUM_SRC-1:0]     rs_used_id,
    input  logic [AW-1:0]          rd_ex,
    input  logic                   mem_read_ex,
    input  logic [AW-1:0]          rd_mem,
    input  logic                   reg_write_mem,
    input  logic [AW-1:0]          rd_wb,
    input  logic                   reg_write_wb,
    input  logic                   dmem_req_mem,
    input  logic                   dmem_ready,
    input  logic                   branch_taken_ex,
    output logic [2*NUM_SRC-1:0]   fwd_sel,
    output logic                   stall_if_id,
    output logic                   bubble_id_ex,
    output logic                   freeze,
    output logic                   flush_if_id,
    output logic                   flush_id_ex,
    output logic [CNT_W-1:0]       stall_cnt,
    output logic [CNT_W-1:0]       flush_cnt
);

    typedef enum logic [1:0] {RUN, LU_STALL, MEM_WAIT} state_t;

    localparam logic [2:0] LU_INIT = 3'(LU_CYC - 1);

    state_t     state, next_state;
    state_t     ret_state, ret_next;
    logic [2:0] cnt, cnt_next;
    logic       lu_hit, lu, dmem_wait;

    always_comb begin
        for (int i = 0; i < NUM_SRC; i++) begin
            fwd_sel[2*i +: 2] = 2'b00;
            if (reg_write_mem && rd_mem != '0 && rd_mem == rs_ex[i*AW +: AW])
                fwd_sel[2*i +: 2] = 2'b10;
            else if (reg_write_wb && rd_wb != '0 && rd_wb == rs_ex[i*AW +: AW])
                fwd_sel[2*i +: 2] = 2'b01;
        end
    end

    always_comb begin
        lu_hit = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (rs_used_id[i] && rs_id[i*AW +: AW] == rd_ex)
                lu_hit = 1'b1;
        end
    end

    assign lu        = mem_read_ex && (rd_ex != '0) && lu_hit;
    assign dmem_wait = dmem_req_mem && !dmem_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            ret_state <= RUN;
            cnt       <= 3'd0;
        end else begin
            state     <= next_state;
            ret_state <= ret_next;
            cnt       <= cnt_next;
        end
    end

    always_comb begin
        next_state   = state;
        ret_next     = ret_state;
        cnt_next     = cnt;
        stall_if_id  = 1'b0;
        bubble_id_ex = 1'b0;
        freeze       = 1'b0;
        flush_if_id  = 1'b0;
        flush_id_ex  = 1'b0;
        case (state)
            RUN: begin
                if (dmem_wait) begin
                    freeze     = 1'b1;
                    next_state = MEM_WAIT;
                    ret_next   = RUN;
                end else if (branch_taken_ex) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                end else if (lu) begin
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    if (LU_CYC > 1) begin
                        cnt_next   = LU_INIT;
                        next_state = LU_STALL;
                    end
                end
            end
            LU_STALL: begin
                // A dmem wait parks the remaining bubble count until the access completes
                if (dmem_wait) begin
                    freeze     = 1'b1;
                    next_state = MEM_WAIT;
                    ret_next   = LU_STALL;
                end else if (branch_taken_ex) begin
                    flush_if_id = 1'b1;
                    flush_id_ex = 1'b1;
                    cnt_next    = 3'd0;
                    next_state  = RUN;
                end else begin
                    stall_if_id  = 1'b1;
                    bubble_id_ex = 1'b1;
                    cnt_next     = cnt - 3'd1;
                    if (cnt <= 3'd1)
                        next_state = RUN;
                end
            end
            MEM_WAIT: begin
                if (dmem_ready)
                    next_state = ret_state;
                else
                    freeze = 1'b1;
            end
            default: next_state = RUN;
        endcase
        // Controls stay quiet while reset is held so no stale bubble escapes
        if (rst) begin
            stall_if_id  = 1'b0;
            bubble_id_ex = 1'b0;
            freeze       = 1'b0;
            flush_if_id  = 1'b0;
            flush_id_ex  = 1'b0;
        end
    end

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if ((stall_if_id || freeze) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 1'b1;
            if (flush_if_id && flush_cnt != '1)
                flush_cnt <= flush_cnt + 1'b1;
        end
    end
`else
    assign stall_cnt = {CNT_W{1'b0}};
    assign flush_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl (LU_CYC=2): expected control vectors go through a scoreboard queue.
module tb_hazard_forward_ctrl;

    localparam int NS  = 2;
    localparam int AWT = 5;
    localparam int CW  = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic [NS*AWT-1:0] rs_ex, rs_id;
    logic [NS-1:0]     rs_used_id;
    logic [AWT-1:0]    rd_ex, rd_mem, rd_wb;
    logic              mem_read_ex, reg_write_mem, reg_write_wb;
    logic              dmem_req_mem, dmem_ready, branch_taken_ex;
    logic [2*NS-1:0]   fwd_sel;
    logic              stall_if_id, bubble_id_ex, freeze, flush_if_id, flush_id_ex;
    logic [CW-1:0]     stall_cnt, flush_cnt;

    int tests  = 0;
    int failed = 0;
    int exp_stall = 0;
    int exp_flush = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    always #5 clk = ~clk;

    hazard_forward_ctrl #(.NUM_SRC(NS), .AW(AWT), .LU_CYC(2), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .rs_ex(rs_ex), .rs_id(rs_id), .rs_used_id(rs_used_id),
        .rd_ex(rd_ex), .mem_read_ex(mem_read_ex), .rd_mem(rd_mem), .reg_write_mem(reg_write_mem),
        .rd_wb(rd_wb), .reg_write_wb(reg_write_wb), .dmem_req_mem(dmem_req_mem),
        .dmem_ready(dmem_ready), .branch_taken_ex(branch_taken_ex), .fwd_sel(fwd_sel),
        .stall_if_id(stall_if_id), .bubble_id_ex(bubble_id_ex), .freeze(freeze),
        .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic idle();
        rs_ex = '0; rs_id = '0; rs_used_id = '0; rd_ex = '0; mem_read_ex = 1'b0;
        rd_mem = '0; reg_write_mem = 1'b0; rd_wb = '0; reg_write_wb = 1'b0;
        dmem_req_mem = 1'b0; dmem_ready = 1'b0; branch_taken_ex = 1'b0;
    endtask

    task automatic set_lu(input logic [AWT-1:0] rd, input logic [NS*AWT-1:0] rs, input logic [NS-1:0] used);
        mem_read_ex = 1'b1; rd_ex = rd; rs_id = rs; rs_used_id = used;
    endtask

    // One clock: push expectation, pop and compare at the falling edge, advance past the next rising edge
    task automatic cyc(input string tag, input logic [3:0] f, input logic st, input logic bu,
                       input logic fr, input logic fl);
        logic [8:0] obs, e;
        string      t;
        exp_q.push_back({f, st, bu, fr, fl, fl});
        tag_q.push_back(tag);
        if (rst) begin
            exp_stall = 0;
            exp_flush = 0;
        end else begin
            if (st || fr) exp_stall++;
            if (fl)       exp_flush++;
        end
        @(negedge clk);
        obs = {fwd_sel, stall_if_id, bubble_id_ex, freeze, flush_if_id, flush_id_ex};
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        tests++;
        assert (obs === e) else begin
            failed++;
            $error("FAIL %s: observed %b expected %b (fwd,stall,bubble,freeze,flush_if,flush_id)", t, obs, e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        @(posedge clk);
        #1;
        cyc("reset_hold", 4'b0000, 0, 0, 0, 0);
        rst = 1'b0;
        cyc("reset_idle", 4'b0000, 0, 0, 0, 0);

        // Forwarding
        rs_ex = {5'd3, 5'd3}; rd_mem = 5'd3; reg_write_mem = 1'b1; rd_wb = 5'd3; reg_write_wb = 1'b1;
        cyc("fwd_mem_prio", 4'b1010, 0, 0, 0, 0);
        rs_ex = {5'd0, 5'd5}; rd_mem = 5'd0; reg_write_mem = 1'b1; rd_wb = 5'd5; reg_write_wb = 1'b1;
        cyc("fwd_x0", 4'b0001, 0, 0, 0, 0);
        rs_ex = {5'd9, 5'd4}; rd_mem = 5'd4; rd_wb = 5'd9;
        cyc("fwd_split", 4'b0110, 0, 0, 0, 0);
        rs_ex = {5'd6, 5'd6}; rd_mem = 5'd6; reg_write_mem = 1'b0; rd_wb = 5'd6;
        cyc("fwd_mem_nowr", 4'b0101, 0, 0, 0, 0);
        reg_write_wb = 1'b0;
        cyc("fwd_none", 4'b0000, 0, 0, 0, 0);
        idle();

        // Reset while waiting on dmem
        dmem_req_mem = 1'b1;
        cyc("rstw_enter", 4'b0000, 0, 0, 1, 0);
        cyc("rstw_wait", 4'b0000, 0, 0, 1, 0);
        rst = 1'b1;
        cyc("rstw_rst", 4'b0000, 0, 0, 0, 0);
        rst = 1'b0; idle();
        cyc("rstw_after", 4'b0000, 0, 0, 0, 0);

        // Reset during load-use stall
        set_lu(5'd7, {5'd7, 5'd2}, 2'b10);
        cyc("rstl_stall", 4'b0000, 1, 1, 0, 0);
        idle(); rst = 1'b1;
        cyc("rstl_rst", 4'b0000, 0, 0, 0, 0);
        rst = 1'b0;
        cyc("rstl_after", 4'b0000, 0, 0, 0, 0);

        // Load-use: two bubbles
        set_lu(5'd7, {5'd7, 5'd2}, 2'b10);
        cyc("lu_c0", 4'b0000, 1, 1, 0, 0);
        cyc("lu_c1", 4'b0000, 1, 1, 0, 0);
        idle();
        cyc("lu_done", 4'b0000, 0, 0, 0, 0);
        set_lu(5'd7, {5'd7, 5'd2}, 2'b01);
        cyc("lu_unused", 4'b0000, 0, 0, 0, 0);
        set_lu(5'd0, {5'd0, 5'd0}, 2'b11);
        cyc("lu_x0", 4'b0000, 0, 0, 0, 0);
        idle();

        // dmem wait in the middle of a load-use stall
        set_lu(5'd7, {5'd7, 5'd2}, 2'b10);
        cyc("luw_c0", 4'b0000, 1, 1, 0, 0);
        idle(); dmem_req_mem = 1'b1;
        cyc("luw_f0", 4'b0000, 0, 0, 1, 0);
        cyc("luw_f1", 4'b0000, 0, 0, 1, 0);
        cyc("luw_f2", 4'b0000, 0, 0, 1, 0);
        dmem_ready = 1'b1;
        cyc("luw_ready", 4'b0000, 0, 0, 0, 0);
        idle();
        cyc("luw_resume", 4'b0000, 1, 1, 0, 0);
        cyc("luw_done", 4'b0000, 0, 0, 0, 0);

        // Branch beats load-use
        set_lu(5'd7, {5'd7, 5'd2}, 2'b10); branch_taken_ex = 1'b1;
        cyc("br_lu", 4'b0000, 0, 0, 0, 1);
        idle();
        cyc("br_lu_after", 4'b0000, 0, 0, 0, 0);

        // Branch during load-use stall
        set_lu(5'd7, {5'd7, 5'd2}, 2'b10);
        cyc("brs_c0", 4'b0000, 1, 1, 0, 0);
        idle(); branch_taken_ex = 1'b1;
        cyc("brs_flush", 4'b0000, 0, 0, 0, 1);
        idle();
        cyc("brs_after", 4'b0000, 0, 0, 0, 0);

        // Freeze masks a branch, which flushes once the access completes
        dmem_req_mem = 1'b1; branch_taken_ex = 1'b1;
        cyc("frz_br", 4'b0000, 0, 0, 1, 0);
        dmem_ready = 1'b1;
        cyc("frz_ready", 4'b0000, 0, 0, 0, 0);
        idle(); branch_taken_ex = 1'b1;
        cyc("frz_flush", 4'b0000, 0, 0, 0, 1);
        idle();
        cyc("frz_done", 4'b0000, 0, 0, 0, 0);

`ifdef HAZ_PERF_CNT_EN
        tests++;
        assert (stall_cnt === CW'(exp_stall)) else begin
            failed++;
            $error("FAIL stall_cnt: observed %0d expected %0d", stall_cnt, exp_stall);
        end
        tests++;
        assert (flush_cnt === CW'(exp_flush)) else begin
            failed++;
            $error("FAIL flush_cnt: observed %0d expected %0d", flush_cnt, exp_flush);
        end
`else
        tests++;
        assert (stall_cnt === '0) else begin
            failed++;
            $error("FAIL stall_cnt_off: observed %0d expected 0", stall_cnt);
        end
        tests++;
        assert (flush_cnt === '0) else begin
            failed++;
            $error("FAIL flush_cnt_off: observed %0d expected 0", flush_cnt);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
